// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
//   Shared definitions for the EX-stage multiply/divide sequencer: ALU op codes
//   handled by the block, FSM state encoding and small op-decode helpers.
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_muldiv(input logic [7:0] op);
        return op inside {EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP};
    endfunction

    function automatic logic is_div(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div.sv
// -----------------------------------------------------------------------------
// div_radix2
//   Iterative unsigned restoring divider, one quotient bit per cycle.
//   A start pulse loads the operands; WIDTH cycles later done pulses for one
//   cycle and quotient/remainder hold the result until the next start.
//   A zero divisor naturally yields quotient = all ones, remainder = dividend.
// Ports
//   clk, rst          clock, async active-high reset
//   start             load operands and begin (restarts any run in progress)
//   dividend, divisor unsigned operands, sampled on start
//   done              one-cycle pulse, result valid
//   quotient          unsigned quotient
//   remainder         unsigned remainder
// -----------------------------------------------------------------------------
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q;
    logic [WIDTH:0]   shifted, diff;

    // Partial remainder shifted left with the next dividend bit; one extra bit
    // because the shifted value can exceed WIDTH bits before the subtract.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                if (!diff[WIDTH]) begin
                    rem_q <= diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//   EX-stage sequencer for MULT/MULTU/DIV/DIVU. Accepts the op from the decoder,
//   stalls the pipeline while the operation runs and issues a single-cycle
//   {hi,lo} write strobe for the HI/LO register.
//   Multiply: latency-modelled, product registered after MUL_LAT cycles.
//   Divide:   WIDTH-cycle magnitude divide (div_radix2) + one sign-fix cycle.
// Ports
//   clk, rst      clock, async active-high reset
//   valid_i       EX instruction valid
//   alucontrol_i  ALU op code; only the four muldiv ops act
//   srca_i/srcb_i rs / rt operands
//   flush_i       squash: abort to IDLE, no write
//   hold_i        downstream stall; DONE waits while high
//   stall_o       hold IF/ID/EX (accept cycle and MUL/DIV states)
//   busy_o        FSM not IDLE
//   hilo_we_o     one-cycle HI/LO write strobe
//   hi_o/lo_o     result (mult high/low word, remainder/quotient)
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [7:0]       alucontrol_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // Counter must reach both WIDTH-1 and MUL_LAT-1 (at most 7).
    localparam int CW = ($clog2(WIDTH) > 3) ? $clog2(WIDTH) : 3;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;

    logic             start, mul_last, div_last;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_done;
    logic [WIDTH-1:0] div_quo, div_rem;

    // rst gates start so stall_o drops the moment reset is asserted.
    assign start = valid_i & is_muldiv(alucontrol_i) & (state_q == ST_IDLE)
                 & ~flush_i & ~rst;

    assign mul_last = (state_q == ST_MUL) && (cnt_q == CW'(MUL_LAT - 1));
    assign div_last = (state_q == ST_DIV) && (cnt_q == CW'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = is_div(alucontrol_i) ? ST_DIV : ST_MUL;
            ST_MUL:  if (mul_last) state_d = ST_DONE;
            ST_DIV:  if (div_last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (!hold_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       cnt_q <= '0;
        else if (flush_i || start || mul_last || div_last) cnt_q <= '0;
        else if (state_q == ST_MUL || state_q == ST_DIV)   cnt_q <= cnt_q + CW'(1);
    end

    // Raw operands and signedness, kept for the multiplier and the sign fix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
        end else if (start) begin
            a_q   <= srca_i;
            b_q   <= srcb_i;
            sgn_q <= is_signed_op(alucontrol_i);
        end
    end

    // ---------------- divider ----------------
    // Magnitudes feed the divider straight from the operands in the accept
    // cycle so its WIDTH iterations line up with the DIV state.
    assign mag_a = (is_signed_op(alucontrol_i) && srca_i[WIDTH-1]) ? -srca_i : srca_i;
    assign mag_b = (is_signed_op(alucontrol_i) && srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;

    div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (start & is_div(alucontrol_i)),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // ---------------- result datapath ----------------
    logic [2*WIDTH-1:0] ext_a, ext_b, product;
    logic               neg_quo, neg_rem, b_zero;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Sign-extend for MULT, zero-extend for MULTU; the low 2*WIDTH bits of
    // the extended product are correct for both.
    assign ext_a   = {{WIDTH{a_q[WIDTH-1] & sgn_q}}, a_q};
    assign ext_b   = {{WIDTH{b_q[WIDTH-1] & sgn_q}}, b_q};
    assign product = ext_a * ext_b;

    // Truncating division: quotient negative when signs differ, remainder
    // follows the dividend. 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign neg_quo = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign neg_rem = sgn_q & a_q[WIDTH-1];
    assign quo_fix = neg_quo ? -div_quo : div_quo;
    assign rem_fix = neg_rem ? -div_rem : div_rem;
    assign b_zero  = (b_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (!flush_i) begin
            if (mul_last) begin
                {hi_o, lo_o} <= product;
            end else if (state_q == ST_FIX && div_done) begin
                if (b_zero) begin
                    // Divide by zero: no trap, raw dividend in HI.
                    hi_o <= a_q;
                    lo_o <= '1;
                end else begin
                    hi_o <= rem_fix;
                    lo_o <= quo_fix;
                end
            end
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign stall_o   = start | (state_q == ST_MUL) | (state_q == ST_DIV);
    assign hilo_we_o = (state_q == ST_DONE) & ~hold_i & ~flush_i;

endmodule
